store_buffer: RTL and testbench

- Posted-write FIFO between the single-cycle core's memory-access stage and the data memory (DM).
- Accepts CPU stores in one cycle and drains them to DM one per cycle, in order, on cycles with no load.
- Forwards buffered store data to CPU loads so the core never observes stale memory.
- Word-addressed throughout: addresses pass to DM unchanged, with no byte-offset shifting.

---
 rtl/store_buffer_if.sv | 32 +++
 rtl/store_buffer.sv | 134 +++++++++++++
 tb/tb_store_buffer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// CPU-side and DM-side signal bundle for the store buffer.
// slave: the buffer itself; master: the core/memory environment driving it.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          cpu_memwrite;
  logic          cpu_memread;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          stall;
  logic          dm_memwrite;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wd;
  logic [DW-1:0] dm_rd;
  logic          empty;
  logic [CW-1:0] count;

  modport slave (
    input  cpu_memwrite, cpu_memread, cpu_addr, cpu_wd, dm_rd,
    output cpu_rd, stall, dm_memwrite, dm_addr, dm_wd, empty, count
  );

  modport master (
    output cpu_memwrite, cpu_memread, cpu_addr, cpu_wd, dm_rd,
    input  cpu_rd, stall, dm_memwrite, dm_addr, dm_wd, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core's memory stage and data memory.
// Build option STB_FWD_EN: forward buffered store data to loads; otherwise stall matching loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full_s;
  logic          hit_s;
  logic          load_port_s;
  logic          drain_s;
  logic          push_s;
  logic          pop_s;
  logic          stall_s;
`ifdef STB_FWD_EN
  logic [DW-1:0] hit_data_s;
`endif

  // Youngest pending entry matching the load address (later age wins).
  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    hit_s = 1'b0;
`ifdef STB_FWD_EN
    hit_data_s = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == bus.cpu_addr)) begin
        hit_s = 1'b1;
`ifdef STB_FWD_EN
        hit_data_s = data_q[idx];
`endif
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // DM port arbitration, stall and push/pop decisions.
  always_comb begin
    full_s = (count_q == CW'(DEPTH));
`ifdef STB_FWD_EN
    load_port_s = bus.cpu_memread;
    stall_s     = bus.cpu_memwrite & (bus.cpu_memread | full_s);
`else
    // A load hitting a pending store yields the port to draining until it no longer hits.
    load_port_s = bus.cpu_memread & ~hit_s;
    stall_s     = (bus.cpu_memwrite & (bus.cpu_memread | full_s)) |
                  (bus.cpu_memread & hit_s);
`endif
    drain_s = ~load_port_s & (count_q != '0);
    // Reset discards a drain in progress so DM keeps its old contents.
    pop_s   = drain_s & ~reset;
    push_s  = bus.cpu_memwrite & ~bus.cpu_memread & ~full_s;
  end

  // Drive the DM port and load data.
  always_comb begin
    bus.dm_memwrite = pop_s;
    bus.stall       = stall_s;
    if (load_port_s) begin
      bus.dm_addr = bus.cpu_addr;
      bus.dm_wd   = '0;
    end else if (drain_s) begin
      bus.dm_addr = addr_q[head_q];
      bus.dm_wd   = data_q[head_q];
    end else begin
      bus.dm_addr = bus.cpu_addr;
      bus.dm_wd   = '0;
    end
`ifdef STB_FWD_EN
    if (hit_s) begin
      bus.cpu_rd = hit_data_s;
    end else begin
      bus.cpu_rd = bus.dm_rd;
    end
`else
    bus.cpu_rd = bus.dm_rd;
`endif
  end

  // Pointer and occupancy next state.
  always_comb begin
    if (pop_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents beyond count are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_q[tail_q] <= bus.cpu_addr;
      data_q[tail_q] <= bus.cpu_wd;
    end
  end

  assign bus.count = count_q;
  assign bus.empty = (count_q == '0);
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts drains,
// load data, stall and occupancy; a monitor pops expectations when the DUT presents outputs.
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic reset;
  logic [31:0] dm_mem  [64];
  logic [31:0] ref_mem [64];
  ent_t        pend[$];
  ent_t        exp_drain[$];
  logic [31:0] exp_load[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  store_buffer_if #(.DEPTH(DEPTH), .AW(32), .DW(32)) sif ();
  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (.clk(clk), .reset(reset), .bus(sif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the clock edge.
  assign sif.dm_rd = dm_mem[sif.dm_addr[5:0]];
  always @(posedge clk) begin
    if (sif.dm_memwrite === 1'b1) dm_mem[sif.dm_addr[5:0]] <= sif.dm_wd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected drains and load data when the DUT presents them.
  always @(negedge clk) begin
    ent_t e;
    logic [31:0] v;
    if (reset === 1'b0 && sif.dm_memwrite === 1'b1) begin
      if (exp_drain.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_drain: got addr %h none expected", sif.dm_addr);
      end else begin
        e = exp_drain.pop_front();
        chk("drain_addr", sif.dm_addr, e.a);
        chk("drain_data", sif.dm_wd, e.d);
      end
    end
    if (reset === 1'b0 && sif.cpu_memread === 1'b1 && sif.dm_memwrite === 1'b0) begin
      if (exp_load.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_load: got %h none expected", sif.cpu_rd);
      end else begin
        v = exp_load.pop_front();
        chk("load_data", sif.cpu_rd, v);
      end
    end
  end

  // One cycle of stimulus plus the reference model's view of that cycle.
  task automatic cyc(input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] d, input logic rst);
    bit hit, blk, svc, drain, full;
    logic [31:0] hv;
    int sz;
    ent_t e;
    reset = rst;
    sif.cpu_memwrite = wr;
    sif.cpu_memread  = rd;
    sif.cpu_addr     = a;
    sif.cpu_wd       = d;
    sz   = pend.size();
    full = (sz == DEPTH);
    hit  = 1'b0;
    hv   = 32'h0;
    foreach (pend[i]) begin
      if (pend[i].a == a) begin
        hit = 1'b1;
        hv  = pend[i].d;
      end
    end
    blk   = !FWD && rd && hit;
    svc   = rd && !blk && !rst;
    drain = !rst && (sz > 0) && (!rd || blk);
    if (svc) exp_load.push_back((FWD && hit) ? hv : ref_mem[a[5:0]]);
    @(negedge clk);
    chk("dm_memwrite", {31'd0, sif.dm_memwrite}, {31'd0, drain});
    if (!rst) begin
      chk("stall", {31'd0, sif.stall}, {31'd0, (wr && (rd || full)) || blk});
      chk("count", {29'd0, sif.count}, sz);
      chk("empty", {31'd0, sif.empty}, {31'd0, sz == 0});
    end
    @(posedge clk);
    if (rst) begin
      pend.delete();
      exp_drain.delete();
    end else begin
      if (drain) begin
        ref_mem[pend[0].a[5:0]] = pend[0].d;
        void'(pend.pop_front());
      end
      if (wr && !rd && !full) begin
        e.a = a;
        e.d = d;
        pend.push_back(e);
        exp_drain.push_back(e);
      end
    end
    #1;
  endtask

  initial begin
    int r;
    for (int i = 0; i < 64; i++) begin
      dm_mem[i]  = 32'hD000_0000 + i;
      ref_mem[i] = 32'hD000_0000 + i;
    end
    dm_mem[9]  = 32'h0000_BEEF;
    ref_mem[9] = 32'h0000_BEEF;
    reset = 1'b1;
    sif.cpu_memwrite = 1'b0;
    sif.cpu_memread  = 1'b0;
    sif.cpu_addr     = 32'd0;
    sif.cpu_wd       = 32'd0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

    // Single store drains on the following cycle.
    cyc(1'b1, 1'b0, 32'd5, 32'h0000_A5A5, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    // Plain load with no matching entry.
    cyc(1'b0, 1'b1, 32'd9, 32'd0, 1'b0);

    // Back-to-back stores with loads interleaved, drain order checked by the scoreboard.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, i, 32'h11 * i, 1'b0);
    cyc(1'b0, 1'b1, 32'd50, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 32'd6, 32'h66, 1'b0);
    cyc(1'b0, 1'b1, 32'd50, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Repeated stores to one address then an immediate load.
    cyc(1'b1, 1'b0, 32'd7, 32'h1, 1'b0);
    cyc(1'b1, 1'b0, 32'd7, 32'h2, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'd7, 32'd0, 1'b0);

    // Illegal store+load together.
    cyc(1'b1, 1'b0, 32'd20, 32'h2020, 1'b0);
    cyc(1'b1, 1'b1, 32'd20, 32'hDEAD, 1'b0);
    cyc(1'b0, 1'b1, 32'd20, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    // Reset with a pending store: DM keeps its old value.
    cyc(1'b1, 1'b0, 32'd12, 32'h1212, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(1'b0, 1'b1, 32'd12, 32'd0, 1'b0);

    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      else if (r < 43) cyc(1'b1, 1'b0, $urandom_range(0, 15), $urandom, 1'b0);
      else if (r < 83) cyc(1'b0, 1'b1, $urandom_range(0, 15), 32'd0, 1'b0);
      else if (r < 88) cyc(1'b1, 1'b1, $urandom_range(0, 15), $urandom, 1'b0);
      else             cyc(1'b0, 1'b0, $urandom_range(0, 15), 32'd0, 1'b0);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

    chk("drains_outstanding", exp_drain.size(), 32'd0);
    chk("loads_outstanding", exp_load.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
